// File: rtl/fsm_ascon_ctrl.sv
// fsm_ascon_ctrl: ASCON-128a round sequencer (init, AD, PT, finalisation), one round per cycle
// Ports: clock_i/reset_i (async, active-high); start_i begins a message from IDLE;
// data_valid_i/data_ready_o block handshake; en_state_o, input_mod_o, round_o and en_xor_*_o
// steer the round datapath; en_cipher_o/en_tag_o capture outputs; cipher_valid_o/tag_valid_o
// flag them; busy_o is high outside IDLE.
module fsm_ascon_ctrl #(
  parameter int NB_AD_BLOCKS = 1,
  parameter int NB_PT_BLOCKS = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       en_state_o,
  output logic       input_mod_o,
  output logic [3:0] round_o,
  output logic       en_xor_data_o,
  output logic       en_xor_begin_key_o,
  output logic       en_xor_lsb_o,
  output logic       en_xor_end_key_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);
  typedef enum logic [2:0] {IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, TAG} state_t;
  localparam logic [3:0] AD_LAST = 4'(NB_AD_BLOCKS - 1);
  localparam logic [3:0] PT_LAST = 4'(NB_PT_BLOCKS - 1);
  state_t state, state_n;
  logic [3:0] rnd_cnt, rnd_n, blk_cnt, blk_n;
  logic last_rnd, fin_blk;
  assign last_rnd = rnd_cnt == 4'd11;
  assign fin_blk = blk_cnt == PT_LAST;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      rnd_cnt <= '0;
      blk_cnt <= '0;
      cipher_valid_o <= 1'b0;
    end else begin
      state <= state_n;
      rnd_cnt <= rnd_n;
      blk_cnt <= blk_n;
      cipher_valid_o <= en_cipher_o;
    end
  end
  always_comb begin
    state_n = state;
    rnd_n = rnd_cnt;
    blk_n = blk_cnt;
    data_ready_o = 1'b0;
    en_state_o = 1'b0;
    input_mod_o = 1'b0;
    round_o = rnd_cnt;
    en_xor_data_o = 1'b0;
    en_xor_begin_key_o = 1'b0;
    en_xor_lsb_o = 1'b0;
    en_xor_end_key_o = 1'b0;
    en_cipher_o = 1'b0;
    en_tag_o = 1'b0;
    tag_valid_o = 1'b0;
    busy_o = state != IDLE;
    case (state)
      IDLE: begin
        round_o = '0;
        if (start_i) begin
          state_n = INIT;
          rnd_n = '0;
          blk_n = '0;
        end
      end
      INIT: begin
        en_state_o = 1'b1;
        input_mod_o = rnd_cnt != 4'd0;
        rnd_n = last_rnd ? 4'd0 : rnd_cnt + 4'd1;
        if (last_rnd) begin
          en_xor_end_key_o = 1'b1;
          en_xor_lsb_o = NB_AD_BLOCKS == 0;
          state_n = NB_AD_BLOCKS == 0 ? WAIT_PT : WAIT_AD;
        end
      end
      WAIT_AD: begin
        data_ready_o = 1'b1;
        input_mod_o = 1'b1;
        round_o = 4'd4;
        if (data_valid_i) begin
          en_state_o = 1'b1;
          en_xor_data_o = 1'b1;
          state_n = AD;
          rnd_n = 4'd5;
        end
      end
      AD: begin
        en_state_o = 1'b1;
        input_mod_o = 1'b1;
        rnd_n = last_rnd ? 4'd0 : rnd_cnt + 4'd1;
        if (last_rnd) begin
          en_xor_lsb_o = blk_cnt == AD_LAST;
          blk_n = blk_cnt == AD_LAST ? 4'd0 : blk_cnt + 4'd1;
          state_n = blk_cnt == AD_LAST ? WAIT_PT : WAIT_AD;
        end
      end
      WAIT_PT: begin
        data_ready_o = 1'b1;
        input_mod_o = 1'b1;
        // the final block skips straight into the 12-round finalisation
        round_o = fin_blk ? 4'd0 : 4'd4;
        if (data_valid_i) begin
          en_state_o = 1'b1;
          en_xor_data_o = 1'b1;
          en_cipher_o = 1'b1;
          en_xor_begin_key_o = fin_blk;
          state_n = fin_blk ? FINAL : PT;
          rnd_n = fin_blk ? 4'd1 : 4'd5;
        end
      end
      PT: begin
        en_state_o = 1'b1;
        input_mod_o = 1'b1;
        rnd_n = last_rnd ? 4'd0 : rnd_cnt + 4'd1;
        if (last_rnd) begin
          blk_n = blk_cnt + 4'd1;
          state_n = WAIT_PT;
        end
      end
      FINAL: begin
        en_state_o = 1'b1;
        input_mod_o = 1'b1;
        rnd_n = last_rnd ? 4'd0 : rnd_cnt + 4'd1;
        if (last_rnd) begin
          en_xor_end_key_o = 1'b1;
          en_tag_o = 1'b1;
          blk_n = '0;
          state_n = TAG;
        end
      end
      TAG: begin
        tag_valid_o = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fsm_ascon_ctrl.sv
// tb_fsm_ascon_ctrl: directed cycle-accurate checks of the ASCON sequencing FSM
module tb_fsm_ascon_ctrl;
  logic clock = 1'b0, reset = 1'b1;
  logic start_a = 1'b0, valid_a = 1'b0, start_b = 1'b0, valid_b = 1'b0;
  logic ready_a, en_state_a, input_mod_a, xor_data_a, begin_key_a, lsb_a, end_key_a;
  logic cipher_a, tag_a, cipher_valid_a, tag_valid_a, busy_a;
  logic ready_b, en_state_b, input_mod_b, xor_data_b, begin_key_b, lsb_b, end_key_b;
  logic cipher_b, tag_b, cipher_valid_b, tag_valid_b, busy_b;
  logic [3:0] round_a, round_b;
  int vectors = 0, miscompares = 0, cyc = 0;
  always #5 clock = ~clock;
  fsm_ascon_ctrl dut_a (
    .clock_i(clock), .reset_i(reset), .start_i(start_a), .data_valid_i(valid_a),
    .data_ready_o(ready_a), .en_state_o(en_state_a), .input_mod_o(input_mod_a),
    .round_o(round_a), .en_xor_data_o(xor_data_a), .en_xor_begin_key_o(begin_key_a),
    .en_xor_lsb_o(lsb_a), .en_xor_end_key_o(end_key_a), .en_cipher_o(cipher_a),
    .en_tag_o(tag_a), .cipher_valid_o(cipher_valid_a), .tag_valid_o(tag_valid_a),
    .busy_o(busy_a)
  );
  fsm_ascon_ctrl #(.NB_AD_BLOCKS(0), .NB_PT_BLOCKS(1)) dut_b (
    .clock_i(clock), .reset_i(reset), .start_i(start_b), .data_valid_i(valid_b),
    .data_ready_o(ready_b), .en_state_o(en_state_b), .input_mod_o(input_mod_b),
    .round_o(round_b), .en_xor_data_o(xor_data_b), .en_xor_begin_key_o(begin_key_b),
    .en_xor_lsb_o(lsb_b), .en_xor_end_key_o(end_key_b), .en_cipher_o(cipher_b),
    .en_tag_o(tag_b), .cipher_valid_o(cipher_valid_b), .tag_valid_o(tag_valid_b),
    .busy_o(busy_b)
  );
  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d want %0d", tag, cyc, act, exp);
    end
  endtask
  function automatic logic [3:0] round_run1(input int c);
    return 4'(c <= 12 ? c - 1 : (c == 13 || c == 21 || c == 29) ? 4 :
              c <= 20 ? c - 9 : c <= 28 ? c - 17 : c <= 36 ? c - 25 : c - 37);
  endfunction
  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    cyc = 0;
    check("reset_busy", {3'b0, busy_a}, 4'd0);
    check("reset_round", round_a, 4'd0);
    // run 1: defaults, valid tied high, stray start mid-message
    @(posedge clock);
    #1 start_a = 1'b1; valid_a = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clock);
      #1 start_a = c == 30;
      #1 cyc = c;
      check("en_state", {3'b0, en_state_a}, {3'b0, c <= 48});
      check("ready", {3'b0, ready_a}, {3'b0, c == 13 || c == 21 || c == 29 || c == 37});
      check("input_mod", {3'b0, input_mod_a}, {3'b0, c >= 2 && c <= 48});
      if (c <= 48) check("round", round_a, round_run1(c));
      check("xor_data", {3'b0, xor_data_a}, {3'b0, c == 13 || c == 21 || c == 29 || c == 37});
      check("cipher", {3'b0, cipher_a}, {3'b0, c == 21 || c == 29 || c == 37});
      check("cipher_valid", {3'b0, cipher_valid_a}, {3'b0, c == 22 || c == 30 || c == 38});
      check("begin_key", {3'b0, begin_key_a}, {3'b0, c == 37});
      check("lsb", {3'b0, lsb_a}, {3'b0, c == 20});
      check("end_key", {3'b0, end_key_a}, {3'b0, c == 12 || c == 48});
      check("tag", {3'b0, tag_a}, {3'b0, c == 48});
      check("tag_valid", {3'b0, tag_valid_a}, {3'b0, c == 49});
      check("busy", {3'b0, busy_a}, {3'b0, c <= 49});
    end
    // run 2: five-cycle stall at the first PT block
    #1 start_a = 1'b1;
    for (int c = 1; c <= 56; c++) begin
      @(posedge clock);
      #1 start_a = 1'b0; valid_a = !(c >= 21 && c <= 25);
      #1 cyc = 100 + c;
      if (c >= 21 && c <= 25) begin
        check("bp_ready", {3'b0, ready_a}, 4'd1);
        check("bp_en_state", {3'b0, en_state_a}, 4'd0);
        check("bp_cipher", {3'b0, cipher_a}, 4'd0);
        check("bp_busy", {3'b0, busy_a}, 4'd1);
      end
      if (c == 22) check("bp_no_cvalid", {3'b0, cipher_valid_a}, 4'd0);
      if (c == 26) begin
        check("bp_accept", {2'b0, en_state_a, cipher_a}, 4'd3);
        check("bp_round4", round_a, 4'd4);
      end
      if (c == 27) begin
        check("bp_cvalid", {3'b0, cipher_valid_a}, 4'd1);
        check("bp_round5", round_a, 4'd5);
      end
      if (c == 42) check("bp_begin_key", {3'b0, begin_key_a}, 4'd1);
      if (c == 53) check("bp_tag", {3'b0, tag_a}, 4'd1);
      if (c == 54) check("bp_tag_valid", {3'b0, tag_valid_a}, 4'd1);
      if (c == 55) check("bp_idle", {3'b0, busy_a}, 4'd0);
    end
    // run 3: async reset in FINAL, then clean restart
    #1 start_a = 1'b1; valid_a = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1 start_a = 1'b0;
    end
    cyc = 200;
    reset = 1'b1;
    #1;
    check("rst_busy", {3'b0, busy_a}, 4'd0);
    check("rst_en_state", {3'b0, en_state_a}, 4'd0);
    check("rst_round", round_a, 4'd0);
    check("rst_outs", {ready_a, input_mod_a, end_key_a, tag_valid_a}, 4'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    check("rst_hold", {3'b0, busy_a}, 4'd0);
    #1 start_a = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clock);
      #1 start_a = 1'b0;
      #1 cyc = 200 + c;
      if (c == 1) check("rs_first", {1'b0, busy_a, en_state_a, input_mod_a}, 4'd6);
      if (c == 1) check("rs_round", round_a, 4'd0);
      if (c == 13) check("rs_ready", {3'b0, ready_a}, 4'd1);
      if (c == 49) check("rs_tag_valid", {3'b0, tag_valid_a}, 4'd1);
    end
    // run 4: no AD, single PT block
    #1 start_b = 1'b1; valid_b = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      @(posedge clock);
      #1 start_b = 1'b0;
      #1 cyc = 300 + c;
      check("b_lsb", {3'b0, lsb_b}, {3'b0, c == 12});
      check("b_end_key", {3'b0, end_key_b}, {3'b0, c == 12 || c == 24});
      check("b_ready", {3'b0, ready_b}, {3'b0, c == 13});
      check("b_begin_key", {3'b0, begin_key_b}, {3'b0, c == 13});
      check("b_tag_valid", {3'b0, tag_valid_b}, {3'b0, c == 25});
      check("b_busy", {3'b0, busy_b}, {3'b0, c <= 25});
      if (c == 13) check("b_round", round_b, 4'd0);
      if (c == 14) check("b_round1", round_b, 4'd1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
